// File: rtl/safety_jtag_dtm.sv
// JTAG debug transport module. It brings the JTAG pins into clk_i, runs the TAP controller,
// and bridges the DMI data register onto a valid/ready request/response port.
module safety_jtag_dtm #(
    parameter logic [31:0] IdCode       = 32'h1000_0db3,
    parameter int          IrLength     = 5,
    parameter int          DmiAddrWidth = 7
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    jtag_tck_i,
    input  logic                    jtag_tms_i,
    input  logic                    jtag_tdi_i,
    input  logic                    jtag_trst_ni,
    output logic                    jtag_tdo_o,
    output logic                    jtag_tdo_oe_o,
    output logic                    dmi_req_valid_o,
    input  logic                    dmi_req_ready_i,
    output logic [DmiAddrWidth-1:0] dmi_req_addr_o,
    output logic [1:0]              dmi_req_op_o,
    output logic [31:0]             dmi_req_data_o,
    input  logic                    dmi_resp_valid_i,
    output logic                    dmi_resp_ready_o,
    input  logic [31:0]             dmi_resp_data_i,
    input  logic [1:0]              dmi_resp_op_i
);
    localparam int DrWidth = DmiAddrWidth + 34;
    localparam logic [IrLength-1:0] IrIdcode  = IrLength'(5'h01);
    localparam logic [IrLength-1:0] IrDtmcs   = IrLength'(5'h10);
    localparam logic [IrLength-1:0] IrDmi     = IrLength'(5'h11);
    localparam logic [IrLength-1:0] IrCapture = IrLength'(5'h01);

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR, CAPTURE_DR,
        SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR,
        UPDATE_DR, SELECT_IR, CAPTURE_IR, SHIFT_IR,
        EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
    } tap_state_e;

    logic [1:0]              tck_sync_r, tms_sync_r, tdi_sync_r, trst_sync_r;
    logic                    tck_prev_r;
    tap_state_e              tap_state_r, tap_next_s;
    logic [IrLength-1:0]     ir_r, ir_shift_r;
    logic [DrWidth-1:0]      dr_shift_r, capture_s, shift_s;
    logic                    tdo_r, tdo_oe_r;
    logic                    req_valid_r, resp_ready_r, outstanding_r;
    logic                    sticky_busy_r, sticky_err_r;
    logic [DmiAddrWidth-1:0] req_addr_r;
    logic [1:0]              req_op_r, dmi_stat_s;
    logic [31:0]             req_data_r, rdata_r, dtmcs_s;
    logic                    tms_s, tdi_s, trst_s, rise_s, fall_s;
    logic                    sel_idcode_s, sel_dtmcs_s, sel_dmi_s;
    logic                    update_s, dmi_update_s, dtmcs_update_s, resp_fire_s;
    logic [1:0]              dr_op_s;

    assign tms_s  = tms_sync_r[1];
    assign tdi_s  = tdi_sync_r[1];
    assign trst_s = trst_sync_r[1];
    assign rise_s = tck_sync_r[1] & ~tck_prev_r;
    assign fall_s = ~tck_sync_r[1] & tck_prev_r;

    assign sel_idcode_s   = (ir_r == IrIdcode);
    assign sel_dtmcs_s    = (ir_r == IrDtmcs);
    assign sel_dmi_s      = (ir_r == IrDmi);
    assign update_s       = rise_s && trst_s && (tap_state_r == UPDATE_DR);
    assign dmi_update_s   = update_s && sel_dmi_s;
    assign dtmcs_update_s = update_s && sel_dtmcs_s;
    assign resp_fire_s    = dmi_resp_valid_i && resp_ready_r;
    assign dr_op_s        = dr_shift_r[1:0];

    assign dmi_stat_s = (outstanding_r || sticky_busy_r) ? 2'd3 : (sticky_err_r ? 2'd2 : 2'd0);
    assign dtmcs_s    = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, dmi_stat_s, 6'(DmiAddrWidth), 4'd1};

    assign jtag_tdo_o       = tdo_r;
    assign jtag_tdo_oe_o    = tdo_oe_r;
    assign dmi_req_valid_o  = req_valid_r;
    assign dmi_req_addr_o   = req_addr_r;
    assign dmi_req_op_o     = req_op_r;
    assign dmi_req_data_o   = req_data_r;
    assign dmi_resp_ready_o = resp_ready_r;

    // Pin synchronizers and TCK edge detection; TRSTn idles deasserted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tck_sync_r  <= 2'b00;
            tms_sync_r  <= 2'b00;
            tdi_sync_r  <= 2'b00;
            trst_sync_r <= 2'b11;
            tck_prev_r  <= 1'b0;
        end else begin
            tck_sync_r  <= {tck_sync_r[0], jtag_tck_i};
            tms_sync_r  <= {tms_sync_r[0], jtag_tms_i};
            tdi_sync_r  <= {tdi_sync_r[0], jtag_tdi_i};
            trst_sync_r <= {trst_sync_r[0], jtag_trst_ni};
            tck_prev_r  <= tck_sync_r[1];
        end
    end

    // IEEE 1149.1 TAP next-state table.
    always_comb begin
        tap_next_s = tap_state_r;
        case (tap_state_r)
            TEST_LOGIC_RESET: tap_next_s = tms_s ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    tap_next_s = tms_s ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:        tap_next_s = tms_s ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       tap_next_s = tms_s ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR:         tap_next_s = tms_s ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR:         tap_next_s = tms_s ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         tap_next_s = tms_s ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR:         tap_next_s = tms_s ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        tap_next_s = tms_s ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_IR:        tap_next_s = tms_s ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       tap_next_s = tms_s ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR:         tap_next_s = tms_s ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR:         tap_next_s = tms_s ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         tap_next_s = tms_s ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR:         tap_next_s = tms_s ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        tap_next_s = tms_s ? SELECT_DR : RUN_TEST_IDLE;
            default:          tap_next_s = TEST_LOGIC_RESET;
        endcase
    end

    // Capture and shift values of the DR selected by the current instruction.
    always_comb begin
        capture_s = '0;
        shift_s   = dr_shift_r;
        if (sel_dmi_s) begin
            capture_s = {req_addr_r, rdata_r, dmi_stat_s};
            shift_s   = {tdi_s, dr_shift_r[DrWidth-1:1]};
        end else if (sel_idcode_s || sel_dtmcs_s) begin
            capture_s = sel_idcode_s ? DrWidth'(IdCode) : DrWidth'(dtmcs_s);
            shift_s[31:0] = {tdi_s, dr_shift_r[31:1]};
        end else begin
            shift_s[0] = tdi_s;
        end
    end

    // TAP controller, IR/DR shift registers and TDO; OE tracks the next state so it is aligned with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tap_state_r <= TEST_LOGIC_RESET;
            ir_r        <= IrIdcode;
            ir_shift_r  <= '0;
            dr_shift_r  <= '0;
            tdo_r       <= 1'b0;
            tdo_oe_r    <= 1'b0;
        end else if (!trst_s) begin
            tap_state_r <= TEST_LOGIC_RESET;
            ir_r        <= IrIdcode;
            tdo_oe_r    <= 1'b0;
        end else begin
            if (rise_s) begin
                tap_state_r <= tap_next_s;
                tdo_oe_r    <= (tap_next_s == SHIFT_DR) || (tap_next_s == SHIFT_IR);
                case (tap_state_r)
                    TEST_LOGIC_RESET: ir_r       <= IrIdcode;
                    CAPTURE_IR:       ir_shift_r <= IrCapture;
                    SHIFT_IR:         ir_shift_r <= {tdi_s, ir_shift_r[IrLength-1:1]};
                    UPDATE_IR:        ir_r       <= ir_shift_r;
                    CAPTURE_DR:       dr_shift_r <= capture_s;
                    SHIFT_DR:         dr_shift_r <= shift_s;
                    default:          tdo_oe_r   <= (tap_next_s == SHIFT_DR) || (tap_next_s == SHIFT_IR);
                endcase
            end
            if (fall_s) begin
                tdo_r <= (tap_state_r == SHIFT_IR) ? ir_shift_r[0] : dr_shift_r[0];
            end
        end
    end

    // DMI request/response bridge; a response is retired before a same-cycle update is judged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_valid_r   <= 1'b0;
            resp_ready_r  <= 1'b0;
            outstanding_r <= 1'b0;
            sticky_busy_r <= 1'b0;
            sticky_err_r  <= 1'b0;
            req_addr_r    <= '0;
            req_op_r      <= 2'd0;
            req_data_r    <= 32'd0;
            rdata_r       <= 32'd0;
        end else begin
            if (resp_fire_s) begin
                rdata_r       <= dmi_resp_data_i;
                resp_ready_r  <= 1'b0;
                outstanding_r <= 1'b0;
                if (dmi_resp_op_i == 2'd2) begin
                    sticky_err_r <= 1'b1;
                end
            end
            if (req_valid_r && dmi_req_ready_i) begin
                req_valid_r  <= 1'b0;
                resp_ready_r <= 1'b1;
            end
            if (dmi_update_s) begin
                if (outstanding_r && !resp_fire_s) begin
                    sticky_busy_r <= 1'b1;
                end else if ((dr_op_s == 2'd1) || (dr_op_s == 2'd2)) begin
                    req_addr_r    <= dr_shift_r[DrWidth-1:34];
                    req_data_r    <= dr_shift_r[33:2];
                    req_op_r      <= dr_op_s;
                    req_valid_r   <= 1'b1;
                    outstanding_r <= 1'b1;
                end
            end
            if (dtmcs_update_s && (dr_shift_r[16] || dr_shift_r[17])) begin
                sticky_busy_r <= 1'b0;
                sticky_err_r  <= 1'b0;
            end
            if (dtmcs_update_s && dr_shift_r[17]) begin
                outstanding_r <= 1'b0;
                req_valid_r   <= 1'b0;
                resp_ready_r  <= 1'b0;
            end
        end
    end
endmodule
